// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run sequencer for the CPU core / instruction memory pair.
// Loads a program into imem while the core is held in reset, releases it,
// counts run cycles until the PC hits halt_pc or the budget runs out, then
// captures x31 as the run result.
//
// Optional feature macro: RUN_CTRL_LDSUM_EN
//   defined   -> ld_sum is a running modulo-2^32 sum of the accepted words
//   undefined -> ld_sum is tied to zero and no adder is built
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | core in reset, waiting for start
// LOAD     | accepting program words, one imem write per accepted word
// RELEASE  | one settle cycle so the final imem write lands before fetch
// RUN      | core out of reset, cycle counter and budget timer running
// DONE     | core back in reset, result / timeout / cycle_count held

module cpu_run_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    input  logic [31:0]       cpu_pc,
    input  logic [31:0]       cpu_x31,
    input  logic [31:0]       halt_pc,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [31:0]       result,
    output logic [31:0]       ld_sum
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Highest imem word address; a transfer here ends the load (no wrap).
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    // The budget is tracked by a down-counter that hits zero on the same
    // cycle the up-counting cycle_count reaches MAX_CYCLES-1.
    localparam logic [CNT_W-1:0] BUDGET_LOAD = CNT_W'(MAX_CYCLES - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] word_cnt;
    logic [CNT_W-1:0]  budget_tmr;

    logic in_load;
    logic in_run;
    logic start_ok;
    logic xfer;
    logic load_end;
    logic halt_hit;
    logic budget_hit;

    // Decode of the current state and the events that move the FSM.
    always_comb begin
        in_load    = (state == ST_LOAD);
        in_run     = (state == ST_RUN);
        start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
        xfer       = in_load && ld_valid && ld_ready;
        load_end   = xfer && (ld_last || (word_cnt == LAST_ADDR));
        halt_hit   = (cpu_pc == halt_pc);
        budget_hit = (budget_tmr == '0);
    end

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_end) begin
                        state_nxt = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (halt_hit || budget_hit) begin
                        state_nxt = ST_DONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_reset <= 1'b1;
            ld_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cpu_reset <= (state_nxt != ST_RUN);
            ld_ready  <= (state_nxt == ST_LOAD);
            busy      <= (state_nxt == ST_LOAD) || (state_nxt == ST_RELEASE) ||
                         (state_nxt == ST_RUN);
            done      <= (state_nxt == ST_DONE);
        end
    end

    // Load word counter: cleared on an honoured start, one step per transfer,
    // parked at the last address so it never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
        end else if (!abort) begin
            if (start_ok) begin
                word_cnt <= '0;
            end else if (xfer && (word_cnt != LAST_ADDR)) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // imem write port: one strobe the cycle after each transfer. An abort on
    // the transfer edge drops the write entirely.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= xfer && !abort;
            if (xfer && !abort) begin
                imem_waddr <= word_cnt;
                imem_wdata <= ld_data;
            end
        end
    end

    // Run accounting: cycle counter, budget timer and result capture.
    // Halt is checked before the budget so a simultaneous hit is a clean halt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            budget_tmr  <= '0;
            result      <= '0;
            timeout     <= 1'b0;
        end else if (!abort) begin
            if (start_ok) begin
                cycle_count <= '0;
                budget_tmr  <= BUDGET_LOAD;
                result      <= '0;
                timeout     <= 1'b0;
            end else if (in_run) begin
                if (halt_hit) begin
                    result  <= cpu_x31;
                    timeout <= 1'b0;
                end else if (budget_hit) begin
                    result  <= cpu_x31;
                    timeout <= 1'b1;
                end else begin
                    cycle_count <= cycle_count + 1'b1;
                    budget_tmr  <= budget_tmr - 1'b1;
                end
            end
        end
    end

`ifdef RUN_CTRL_LDSUM_EN
    // Running checksum of accepted program words; frozen outside LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_sum <= '0;
        end else if (!abort) begin
            if (start_ok) begin
                ld_sum <= '0;
            end else if (xfer) begin
                ld_sum <= ld_sum + ld_data;
            end
        end
    end
`else
    // Checksum disabled: constant zero.
    assign ld_sum = 32'h0;
`endif

endmodule
